// File: rtl/sar_pkg.sv
// Shared types for the successive-approximation search controller.
package sar_pkg;

    // Controller state.
    typedef enum logic [1:0] {
        IDLE,
        PROBE,
        DONE
    } state_e;

    // Decoded comparator response; BAD covers no flag or several flags.
    typedef enum logic [1:0] {
        LT,
        ET,
        GT,
        BAD
    } flag_e;

endpackage

// File: rtl/sar_flag_decode.sv
// Maps the comparator lt/et/gt flags onto flag_e; anything not one-hot is BAD.
module sar_flag_decode
    import sar_pkg::*;
(
    input  logic  i_lt,
    input  logic  i_et,
    input  logic  i_gt,
    output flag_e o_flag
);

    // One-hot check and decode in a single lookup.
    always_comb begin
        case ({i_lt, i_et, i_gt})
            3'b100:  o_flag = LT;
            3'b010:  o_flag = ET;
            3'b001:  o_flag = GT;
            default: o_flag = BAD;
        endcase
    end

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search controller: drives probe values to an
// external magnitude comparator and binary-searches the unsigned range.
module sar_search
    import sar_pkg::*;
#(
    parameter int W       = 32,
    parameter int CMP_LAT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     lt,
    input  logic                     et,
    input  logic                     gt,
    output logic [W-1:0]             probe,
    output logic                     probe_vld,
    output logic                     busy,
    output logic                     done,
    output logic                     found,
    output logic                     err,
    output logic [W-1:0]             result,
    output logic [$clog2(W+2)-1:0]   iters
);

    localparam int IW = $clog2(W + 2);
    localparam int CW = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;

    state_e          r_state;
    logic [W-1:0]    r_lo;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_probe;
    logic [CW-1:0]   r_wait;
    logic [IW-1:0]   r_iters;
    logic            r_found;
    logic            r_err;
    logic [W-1:0]    r_result;
    logic            r_done;
    logic            r_busy;
    logic            r_vld;

    flag_e           w_flag;
    logic [W-1:0]    w_lo_n;
    logic [W-1:0]    w_hi_n;
    logic [W-1:0]    w_mid_n;
    logic [IW-1:0]   w_iters_inc;
    logic            w_sample;
    logic            w_cap;
    logic            w_hit;
    logic            w_bad;
    logic            w_end;

    sar_flag_decode u_dec (
        .i_lt   (lt),
        .i_et   (et),
        .i_gt   (gt),
        .o_flag (w_flag)
    );

    assign w_sample    = (r_wait == CW'(CMP_LAT));
    assign w_iters_inc = r_iters + IW'(1);
    assign w_cap       = (w_iters_inc == IW'(W + 1));

    // Narrowed range and next midpoint, plus the termination decision.
    always_comb begin
        w_lo_n = r_lo;
        w_hi_n = r_hi;
        case (w_flag)
            LT:      w_hi_n = r_probe - W'(1);
            GT:      w_lo_n = r_probe + W'(1);
            default: ;
        endcase
        w_mid_n = w_lo_n + ((w_hi_n - w_lo_n) >> 1);
        w_hit   = (w_flag == ET);
        w_bad   = (w_flag == BAD);
        // The probe==lo / probe==hi guards stop the range from wrapping.
        w_end   = w_hit | w_bad
                | ((w_flag == LT) && (r_probe == r_lo))
                | ((w_flag == GT) && (r_probe == r_hi))
                | w_cap;
    end

    // Search FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_lo     <= '0;
            r_hi     <= '1;
            r_probe  <= '0;
            r_wait   <= '0;
            r_iters  <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_vld    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= PROBE;
                        r_lo     <= '0;
                        r_hi     <= '1;
                        r_probe  <= {1'b0, {(W-1){1'b1}}};
                        r_wait   <= '0;
                        r_iters  <= '0;
                        r_found  <= 1'b0;
                        r_err    <= 1'b0;
                        r_result <= '0;
                        r_busy   <= 1'b1;
                        r_vld    <= 1'b1;
                    end
                end
                PROBE: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_vld   <= 1'b0;
                    end else if (!w_sample) begin
                        r_wait <= r_wait + CW'(1);
                    end else begin
                        r_wait  <= '0;
                        r_iters <= w_iters_inc;
                        if (w_end) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_vld   <= 1'b0;
                            r_found <= w_hit;
                            r_err   <= w_bad;
                            if (w_hit) begin
                                r_result <= r_probe;
                            end
                        end else begin
                            r_lo    <= w_lo_n;
                            r_hi    <= w_hi_n;
                            r_probe <= w_mid_n;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign probe     = r_probe;
    assign probe_vld = r_vld;
    assign busy      = r_busy;
    assign done      = r_done;
    assign found     = r_found;
    assign err       = r_err;
    assign result    = r_result;
    assign iters     = r_iters;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: a combinational comparator (CMP_LAT=0)
// and a two-stage pipelined comparator (CMP_LAT=2), each on its own instance.
module tb_sar_search;

    localparam int M_NORM  = 0;
    localparam int M_FAULT = 1;
    localparam int M_ALLLT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Instance 0: CMP_LAT = 0
    logic        start0 = 1'b0, abort0 = 1'b0;
    logic        lt0, et0, gt0;
    logic [31:0] probe0, result0;
    logic        vld0, busy0, done0, found0, err0;
    logic [5:0]  iters0;
    logic [31:0] tgt0 = '0;
    int          mode0 = M_NORM;
    int          idx0;

    // Instance 2: CMP_LAT = 2
    logic        start2 = 1'b0, abort2 = 1'b0;
    logic        lt2, et2, gt2;
    logic [31:0] probe2, result2;
    logic        vld2, busy2, done2, found2, err2;
    logic [5:0]  iters2;
    logic [31:0] tgt2 = '0;
    logic [31:0] s1, s2;

    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        f;
        logic        e;
        logic [31:0] r;
        int          n;
        string       name;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] tgt;
        int          mode;
        logic        f;
        logic        e;
        logic [31:0] r;
        int          n;
        string       name;
    } vec_t;
    vec_t vt[5];

    // Probe-hold monitor on the latency-2 instance.
    logic        h_vld = 1'b0;
    logic [31:0] h_probe = '0;
    int          h_run = 0, h_bad = 0, h_nprobes = 0;

    always #5 clk = ~clk;

    sar_search #(.W(32), .CMP_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .lt(lt0), .et(et0), .gt(gt0),
        .probe(probe0), .probe_vld(vld0), .busy(busy0), .done(done0),
        .found(found0), .err(err0), .result(result0), .iters(iters0)
    );

    sar_search #(.W(32), .CMP_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .lt(lt2), .et(et2), .gt(gt2),
        .probe(probe2), .probe_vld(vld2), .busy(busy2), .done(done2),
        .found(found2), .err(err2), .result(result2), .iters(iters2)
    );

    // Probe index within the current search of instance 0 (1-based while valid).
    always @(posedge clk or posedge rst) begin
        if (rst)        idx0 <= 0;
        else if (!vld0) idx0 <= 1;
        else            idx0 <= idx0 + 1;
    end

    // Comparator for instance 0, with fault-injection modes.
    always_comb begin
        lt0 = (tgt0 < probe0);
        et0 = (tgt0 == probe0);
        gt0 = (tgt0 > probe0);
        if (mode0 == M_ALLLT) begin
            lt0 = 1'b1; et0 = 1'b0; gt0 = 1'b0;
        end else if (mode0 == M_FAULT && idx0 == 3) begin
            lt0 = 1'b1; et0 = 1'b0; gt0 = 1'b1;
        end
    end

    // Comparator for instance 2: flags reflect the probe two edges ago.
    always @(posedge clk) begin
        s1 <= probe2;
        s2 <= s1;
    end
    assign lt2 = (tgt2 < s2);
    assign et2 = (tgt2 == s2);
    assign gt2 = (tgt2 > s2);

    always @(negedge clk) begin
        h_vld   <= vld2;
        h_probe <= probe2;
        if (vld2) begin
            if (h_vld && probe2 == h_probe) begin
                h_run <= h_run + 1;
            end else begin
                if (h_vld && h_run != 3) h_bad <= h_bad + 1;
                h_run     <= 1;
                h_nprobes <= h_nprobes + 1;
            end
        end else if (h_vld && h_run != 3) begin
            h_bad <= h_bad + 1;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference search on 64-bit bounds using floor((lo+hi)/2).
    function automatic void model(input logic [31:0] t, input int mode,
                                  output logic f, output logic e,
                                  output logic [31:0] r, output int n);
        longint lo = 0;
        longint hi = 64'hFFFF_FFFF;
        longint p;
        f = 1'b0; e = 1'b0; r = '0; n = 0;
        for (int k = 1; k <= 40; k++) begin
            p = (lo + hi) / 2;
            n = k;
            if (mode == M_FAULT && k == 3) begin
                e = 1'b1;
                return;
            end
            if (mode != M_ALLLT && longint'(t) == p) begin
                f = 1'b1;
                r = p[31:0];
                return;
            end
            if (mode == M_ALLLT || longint'(t) < p) begin
                if (p == lo) return;
                hi = p - 1;
            end else begin
                if (p == hi) return;
                lo = p + 1;
            end
            if (k == 33) return;
        end
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 0) ? done0 : done2;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else          start2 = v;
    endtask

    // Push expectation, start a search, wait for done, pop and compare.
    task automatic run(input int sel, input logic [31:0] tgt, input int mode,
                       input logic f, input logic e, input logic [31:0] r,
                       input int n, input string name, input int poke,
                       output int cyc);
        exp_t x;
        x.f = f; x.e = e; x.r = r; x.n = n; x.name = name;
        sb.push_back(x);
        if (sel == 0) begin
            tgt0 = tgt; mode0 = mode;
        end else begin
            tgt2 = tgt;
        end
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        cyc = 1;
        while (!done_of(sel) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            set_start(sel, cyc == poke);
        end
        set_start(sel, 1'b0);
        x = sb.pop_front();
        if (!done_of(sel)) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done after %0d cycles", x.name, cyc);
        end else if (sel == 0) begin
            chk({x.name, "_found"},  found0,  x.f);
            chk({x.name, "_err"},    err0,    x.e);
            chk({x.name, "_result"}, result0, x.r);
            chk({x.name, "_iters"},  iters0,  x.n);
        end else begin
            chk({x.name, "_found"},  found2,  x.f);
            chk({x.name, "_err"},    err2,    x.e);
            chk({x.name, "_result"}, result2, x.r);
            chk({x.name, "_iters"},  iters2,  x.n);
        end
    endtask

    initial begin
        int          cyc;
        logic        mf, me;
        logic [31:0] mr, t;
        int          mn;
        logic        seen;

        vt[0] = '{32'h7FFF_FFFF, M_NORM,  1'b1, 1'b0, 32'h7FFF_FFFF, 1,  "mid"};
        vt[1] = '{32'h0000_0000, M_NORM,  1'b1, 1'b0, 32'h0000_0000, 32, "zero"};
        vt[2] = '{32'hFFFF_FFFF, M_NORM,  1'b1, 1'b0, 32'hFFFF_FFFF, 33, "ones"};
        vt[3] = '{32'h1234_5678, M_FAULT, 1'b0, 1'b1, 32'h0000_0000, 3,  "fault"};
        vt[4] = '{32'h0000_0000, M_ALLLT, 1'b0, 1'b0, 32'h0000_0000, 32, "alllt"};

        // Reset values.
        #12;
        chk("rst_probe",  probe0,  0);
        chk("rst_result", result0, 0);
        chk("rst_flags",  {vld0, busy0, done0, found0, err0, iters0}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run(0, vt[i].tgt, vt[i].mode, vt[i].f, vt[i].e, vt[i].r, vt[i].n,
                vt[i].name, -1, cyc);
            if (i == 0) chk("mid_latency", cyc, 2);
        end

        // Latency-2 instance, with an ignored start pulse mid-search.
        run(2, 32'hFFFF_FFFF, M_NORM, 1'b1, 1'b0, 32'hFFFF_FFFF, 33, "lat2", 10, cyc);
        @(negedge clk);
        chk("lat2_hold_bad", h_bad, 0);
        chk("lat2_nprobes",  h_nprobes, 33);

        // Random targets against the reference search.
        for (int i = 0; i < 3; i++) begin
            t = $urandom;
            model(t, M_NORM, mf, me, mr, mn);
            run(0, t, M_NORM, mf, me, mr, mn, "rand", -1, cyc);
        end

        // Abort on the 5th probe: busy/probe_vld drop, no done pulse.
        mode0 = M_ALLLT;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_pre_busy", busy0, 1);
        abort0 = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", busy0, 0);
        chk("abort_vld",  vld0,  0);
        abort0 = 1'b0;
        seen = done0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | done0;
        end
        chk("abort_no_done", seen, 0);

        // Asynchronous reset at the 10th probe, then a clean search.
        mode0 = M_NORM;
        tgt0  = 32'h1234_5678;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_probe",  probe0,  0);
        chk("arst_result", result0, 0);
        chk("arst_flags",  {vld0, busy0, done0, found0, err0, iters0}, 0);
        @(negedge clk);
        rst = 1'b0;
        model(32'h1234_5678, M_NORM, mf, me, mr, mn);
        run(0, 32'h1234_5678, M_NORM, 1'b1, 1'b0, 32'h1234_5678, mn, "after_rst", -1, cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
